seg7_scan_driver: RTL and testbench

Time-multiplexed driver for an N-digit common-anode 7-segment display with active-low segment and digit-select lines.
- Holds a double-buffered BCD/hex value and scans the digits at a programmable refresh rate.
- Inserts a one-cycle anti-ghosting blank interval at every digit change.
- Supports hex glyphs, leading-zero blanking and per-digit decimal points.
- Sits between counter/datapath logic and the board's display pins.

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/seg7_scan_driver_if.sv | 31 +++
 rtl/seg7_glyph.sv | 45 ++++
 rtl/seg7_scan_driver.sv | 129 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan driver.
//   - 7-bit glyph patterns (SEG[7:1] order a..g, active low) for nibbles 0..F
//   - GLYPH_BLANK for a dark digit
//   - bit positions of each segment inside the 8-bit SEG bus
//   - lz_mask(): per-digit leading-zero flags for an N-digit value
package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b0000001;
  localparam logic [6:0] GLYPH_1     = 7'b1001111;
  localparam logic [6:0] GLYPH_2     = 7'b0010010;
  localparam logic [6:0] GLYPH_3     = 7'b0000110;
  localparam logic [6:0] GLYPH_4     = 7'b1001100;
  localparam logic [6:0] GLYPH_5     = 7'b0100100;
  localparam logic [6:0] GLYPH_6     = 7'b0100000;
  localparam logic [6:0] GLYPH_7     = 7'b0001111;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0000100;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b1100000;
  localparam logic [6:0] GLYPH_C     = 7'b0110001;
  localparam logic [6:0] GLYPH_D     = 7'b1000010;
  localparam logic [6:0] GLYPH_E     = 7'b0110000;
  localparam logic [6:0] GLYPH_F     = 7'b0111000;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Bit i of the result is 1 when nibbles n-1 down to i of v are all zero.
  // Bits at or above n are 0. Supports up to 8 digits.
  function automatic logic [7:0] lz_mask(input logic [31:0] v, input int n);
    logic       run;
    logic [7:0] m;
    run = 1'b1;
    m   = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        run  = run & (v[4*i +: 4] == 4'h0);
        m[i] = run;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: value/control inputs and display pins of the scan driver.
//   value    : 4*N_DIGITS nibbles, nibble 0 = rightmost digit
//   dp_in    : per-digit decimal point request
//   load     : single-cycle capture strobe for value/dp_in
//   hex_mode : show A..F for nibbles 10..15 (else blank)
//   blank_lz : suppress leading zeros
//   seg      : active-low segments, bit7=a .. bit1=g, bit0=dp
//   digit    : active-low digit selects
//   frame    : one-cycle pulse after each frame boundary
interface seg7_scan_driver_if #(
  parameter int N_DIGITS = 4
) ();
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  load;
  logic                  hex_mode;
  logic                  blank_lz;
  logic [7:0]            seg;
  logic [N_DIGITS-1:0]   digit;
  logic                  frame;

  modport master (
    output value, dp_in, load, hex_mode, blank_lz,
    input  seg, digit, frame
  );

  modport slave (
    input  value, dp_in, load, hex_mode, blank_lz,
    output seg, digit, frame
  );
endinterface

// File: rtl/seg7_glyph.sv
// seg7_glyph: combinational nibble -> 7-segment pattern (a..g, active low).
//   nibble   : value to show
//   hex_mode : 1 = 10..15 render as A,b,C,d,E,F; 0 = they render blank
//   pattern  : SEG[7:1] pattern
import seg7_pkg::*;

module seg7_glyph (
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] pattern
);

  logic [6:0] hex_pat;

  always_comb begin
    hex_pat = GLYPH_BLANK;
    case (nibble)
      4'hA:    hex_pat = GLYPH_A;
      4'hB:    hex_pat = GLYPH_B;
      4'hC:    hex_pat = GLYPH_C;
      4'hD:    hex_pat = GLYPH_D;
      4'hE:    hex_pat = GLYPH_E;
      4'hF:    hex_pat = GLYPH_F;
      default: hex_pat = GLYPH_BLANK;
    endcase
  end

  always_comb begin
    pattern = GLYPH_BLANK;
    case (nibble)
      4'h0:    pattern = GLYPH_0;
      4'h1:    pattern = GLYPH_1;
      4'h2:    pattern = GLYPH_2;
      4'h3:    pattern = GLYPH_3;
      4'h4:    pattern = GLYPH_4;
      4'h5:    pattern = GLYPH_5;
      4'h6:    pattern = GLYPH_6;
      4'h7:    pattern = GLYPH_7;
      4'h8:    pattern = GLYPH_8;
      4'h9:    pattern = GLYPH_9;
      default: pattern = hex_mode ? hex_pat : GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an N-digit common-anode
// 7-segment display with active-low segment and digit lines.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : seg7_scan_driver_if.slave (value/dp_in/load/hex_mode/blank_lz in,
//         seg/digit/frame out)
// Each digit slot lasts CLK_DIV clocks; the first clock of every slot is
// dark on all lines so the previous digit's segments cannot ghost onto the
// next one. The displayed value is double-buffered and only swaps at frame
// boundaries.
import seg7_pkg::*;

module seg7_scan_driver #(
  parameter int N_DIGITS = 4,
  parameter int CLK_DIV  = 50000
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VW = 4 * N_DIGITS;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [PW-1:0]       pre_q;
  logic [IW-1:0]       idx_q;
  logic [VW-1:0]       act_val_q;
  logic [VW-1:0]       shd_val_q;
  logic [N_DIGITS-1:0] act_dp_q;
  logic [N_DIGITS-1:0] shd_dp_q;
  logic                pending_q;
  logic [7:0]          seg_q;
  logic [N_DIGITS-1:0] digit_q;
  logic                frame_q;

  logic                tick;
  logic                boundary;
  logic [3:0]          cur_nibble;
  logic                cur_dp;
  logic [7:0]          lz;
  logic                cur_lz_blank;
  logic [6:0]          glyph;
  logic [6:0]          cur_pattern;

  assign tick     = (pre_q == PRE_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // A load landing exactly on the boundary goes straight to the active
  // buffer; anything staged earlier in that frame is superseded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_val_q <= '0;
      act_dp_q  <= '0;
      shd_val_q <= '0;
      shd_dp_q  <= '0;
      pending_q <= 1'b0;
    end else if (bus.load && boundary) begin
      act_val_q <= bus.value;
      act_dp_q  <= bus.dp_in;
      pending_q <= 1'b0;
    end else begin
      if (boundary && pending_q) begin
        act_val_q <= shd_val_q;
        act_dp_q  <= shd_dp_q;
        pending_q <= 1'b0;
      end
      if (bus.load) begin
        shd_val_q <= bus.value;
        shd_dp_q  <= bus.dp_in;
        pending_q <= 1'b1;
      end
    end
  end

  // Shifts instead of variable part-selects keep the mux safe for digit
  // counts that are not a power of two.
  assign cur_nibble = 4'(act_val_q >> {idx_q, 2'b00});
  assign cur_dp     = 1'(act_dp_q >> idx_q);
  assign lz         = lz_mask(32'(act_val_q), N_DIGITS);

  assign cur_lz_blank = bus.blank_lz && (idx_q != '0) && 1'(lz >> idx_q);

  seg7_glyph u_glyph (
    .nibble   (cur_nibble),
    .hex_mode (bus.hex_mode),
    .pattern  (glyph)
  );

  assign cur_pattern = cur_lz_blank ? GLYPH_BLANK : glyph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q   <= 8'hFF;
      digit_q <= '1;
      frame_q <= 1'b0;
    end else begin
      frame_q <= boundary;
      if (pre_q == '0) begin
        seg_q   <= 8'hFF;
        digit_q <= '1;
      end else begin
        seg_q[SEG_A:SEG_G] <= cur_pattern;
        seg_q[SEG_DP]      <= ~cur_dp;
        digit_q            <= ~(N_DIGITS'(1) << idx_q);
      end
    end
  end

  assign bus.seg   = seg_q;
  assign bus.digit = digit_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.N_DIGITS(4)) bus ();

  seg7_scan_driver #(.N_DIGITS(4), .CLK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int k      = 0;   // rising edges since the last reset release

  logic [7:0] tab_old [4];
  logic [7:0] tab_new [4];
  int         sw_k;   // edges > sw_k show tab_new, others tab_old

  // Expected {seg, digit, frame} right after edge kk (CLK_DIV=4, N_DIGITS=4):
  // state before edge kk has prescaler (kk-1)%4 and index ((kk-1)/4)%4.
  function automatic logic [12:0] exp_scan(int kk);
    int         d;
    logic [7:0] es;
    logic [3:0] ed;
    d = ((kk - 1) / 4) % 4;
    if (((kk - 1) % 4) == 0) begin
      es = 8'hFF;
      ed = 4'hF;
    end else begin
      es = (kk > sw_k) ? tab_new[d] : tab_old[d];
      ed = ~(4'b0001 << d);
    end
    return {es, ed, (kk % 16) == 0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    bus.value = v;
    bus.dp_in = dp;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if (bus.seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want ff", bus.seg); end
    if (bus.digit !== 4'hF) begin errors++; $display("FAIL reset_digit got %h want f", bus.digit); end
    if (bus.frame !== 1'b0) begin errors++; $display("FAIL reset_frame got %b want 0", bus.frame); end
    rst = 1'b0;
    k = 0;
    tab_old = '{8'h03, 8'h03, 8'h03, 8'h03};
    tab_new = tab_old;
    sw_k = 0;
    while (k < 32) begin
      step(); checks++;
      if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
        errors++; $display("FAIL reset_scan k=%0d got %h want %h", k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
      end
    end
  endtask

  task automatic test_load_midframe();
    tab_new = '{8'h99, 8'h0D, 8'h24, 8'h9F};
    sw_k = 48;
    while (k < 37) begin
      step(); checks++;
      if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
        errors++; $display("FAIL midframe_pre k=%0d got %h want %h", k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
      end
    end
    pulse_load(16'h1234, 4'b0100);
    while (k < 64) begin
      step(); checks++;
      if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
        errors++; $display("FAIL midframe_post k=%0d got %h want %h", k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
      end
    end
  endtask

  task automatic test_hex_lz();
    tab_old = tab_new;
    tab_new = '{8'h49, 8'hFF, 8'h03, 8'h03};
    sw_k = 80;
    while (k < 69) begin
      step(); checks++;
      if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
        errors++; $display("FAIL hex_pre k=%0d got %h want %h", k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
      end
    end
    pulse_load(16'h00A5, 4'b0000);
    for (int phase = 0; phase < 3; phase++) begin
      if (phase == 1) begin
        tab_old = tab_new; tab_new = '{8'h49, 8'h11, 8'h03, 8'h03}; sw_k = 96;
        bus.hex_mode = 1'b1;
      end else if (phase == 2) begin
        tab_old = tab_new; tab_new = '{8'h49, 8'h11, 8'hFF, 8'hFF}; sw_k = 112;
        bus.blank_lz = 1'b1;
      end
      while (k < 96 + 16 * phase) begin
        step(); checks++;
        if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
          errors++; $display("FAIL hex_lz_phase%0d k=%0d got %h want %h", phase, k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
        end
      end
    end
  endtask

  task automatic test_zero_blank();
    tab_old = tab_new;
    tab_new = '{8'h03, 8'hFF, 8'hFF, 8'hFF};
    sw_k = 144;
    while (k < 133) begin
      step(); checks++;
      if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
        errors++; $display("FAIL zero_pre k=%0d got %h want %h", k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
      end
    end
    pulse_load(16'h0000, 4'b0000);
    while (k < 160) begin
      step(); checks++;
      if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
        errors++; $display("FAIL zero_post k=%0d got %h want %h", k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
      end
    end
  endtask

  task automatic test_blank_gap();
    logic [3:0] prev_digit;
    prev_digit = bus.digit;
    while (k < 176) begin
      step(); checks += 2;
      if ($countones(~bus.digit) > 1) begin
        errors++; $display("FAIL gap_onehot k=%0d got digit=%b want at most one low", k, bus.digit);
      end
      if ((prev_digit != 4'hF) && (bus.digit != 4'hF) && (bus.digit != prev_digit)) begin
        errors++; $display("FAIL gap_blank k=%0d got digit %b->%b want blank between", k, prev_digit, bus.digit);
      end
      prev_digit = bus.digit;
    end
  endtask

  task automatic test_back_to_back();
    while (k < 181) begin
      step(); checks++;
      if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
        errors++; $display("FAIL b2b_pre k=%0d got %h want %h", k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
      end
    end
    pulse_load(16'h9999, 4'b0000);
    while (k < 191) begin
      step(); checks++;
      if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
        errors++; $display("FAIL b2b_staged k=%0d got %h want %h", k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
      end
    end
    tab_old = tab_new;
    tab_new = '{8'h00, 8'h1F, 8'h41, 8'h49};
    sw_k = 192;
    pulse_load(16'h5678, 4'b0001);
    while (k < 213) begin
      step(); checks++;
      if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
        errors++; $display("FAIL b2b_boundary k=%0d got %h want %h", k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
      end
    end
    tab_old = tab_new;
    tab_new = '{8'h25, 8'h25, 8'h25, 8'h24};
    sw_k = 224;
    pulse_load(16'h1111, 4'b0000);
    while (k < 216) begin
      step(); checks++;
      if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
        errors++; $display("FAIL b2b_first k=%0d got %h want %h", k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
      end
    end
    pulse_load(16'h2222, 4'b1000);
    while (k < 256) begin
      step(); checks++;
      if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
        errors++; $display("FAIL b2b_last k=%0d got %h want %h", k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
      end
    end
  endtask

  task automatic test_async_reset();
    tab_old = tab_new;
    pulse_load(16'h3333, 4'b1111);
    while (k < 265) begin
      step(); checks++;
      if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
        errors++; $display("FAIL areset_pre k=%0d got %h want %h", k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
      end
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks += 3;
    if (bus.seg !== 8'hFF) begin errors++; $display("FAIL areset_seg got %h want ff", bus.seg); end
    if (bus.digit !== 4'hF) begin errors++; $display("FAIL areset_digit got %h want f", bus.digit); end
    if (bus.frame !== 1'b0) begin errors++; $display("FAIL areset_frame got %b want 0", bus.frame); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    bus.blank_lz = 1'b0;
    bus.hex_mode = 1'b0;
    tab_old = '{8'h03, 8'h03, 8'h03, 8'h03};
    tab_new = tab_old;
    sw_k = 0;
    while (k < 32) begin
      step(); checks++;
      if ({bus.seg, bus.digit, bus.frame} !== exp_scan(k)) begin
        errors++; $display("FAIL areset_post k=%0d got %h want %h", k, {bus.seg, bus.digit, bus.frame}, exp_scan(k));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at k=%0d", k);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.value    = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;
    test_reset();
    test_load_midframe();
    test_hex_lz();
    test_zero_blank();
    test_blank_gap();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
